// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Owns the SDRAM command/address/data pins and time-multiplexes them between
//   the init, auto-refresh, write and read masters. Init owns the bus until
//   init_end. After that one master is granted at a time, with fixed priority
//   aref > write > read. A granted master keeps the bus until its *_end pulse,
//   so there is no preemption.
// Ports
//   clk, rst_n                  clock, async active-low reset
//   init_*/aref_*/wr_*/rd_*     per-master cmd/ba/addr, request and end strobes
//   wr_dq_en, wr_data           write-data drive request and data
//   aref_en, wr_en, rd_en       grants, decoded from the state register
//   sdram_cke                   clock enable, high from first edge after reset
//   sdram_cmd/ba/addr           muxed device command pins
//   sdram_dq_out, sdram_dq_oe   DQ output data and tristate enable
module sdram_arbiter #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned BA_W   = 2,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              init_end,
    input  logic              aref_req,
    input  logic [3:0]        aref_cmd,
    input  logic [BA_W-1:0]   aref_ba,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              aref_end,
    input  logic              wr_req,
    input  logic [3:0]        wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_end,
    input  logic              wr_dq_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic [3:0]        rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_end,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic [3:0]        sdram_cmd,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DATA_W-1:0] sdram_dq_out,
    output logic              sdram_dq_oe
);

    localparam logic [3:0] CmdNop = 4'b0111;

    typedef enum logic [4:0] {
        StInit  = 5'b00001,
        StArbit = 5'b00010,
        StAref  = 5'b00100,
        StWrite = 5'b01000,
        StRead  = 5'b10000
    } state_e;

    state_e state_q, state_d;
    logic   cke_q, cke_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StInit:  if (init_end) state_d = StArbit;
            // Priority resolves same-cycle requests.
            StArbit: begin
                if (aref_req)    state_d = StAref;
                else if (wr_req) state_d = StWrite;
                else if (rd_req) state_d = StRead;
            end
            StAref:  if (aref_end) state_d = StArbit;
            StWrite: if (wr_end)   state_d = StArbit;
            StRead:  if (rd_end)   state_d = StArbit;
            // Any corrupted encoding restarts the device bring-up.
            default: state_d = StInit;
        endcase
    end

    assign cke_d = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StInit;
            cke_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cke_q   <= cke_d;
        end
    end

    assign aref_en   = (state_q == StAref);
    assign wr_en     = (state_q == StWrite);
    assign rd_en     = (state_q == StRead);
    assign sdram_cke = cke_q;

    // The pin mux is combinational on the registered state, so a granted
    // master's command reaches the device without an extra cycle.
    always_comb begin
        sdram_cmd  = init_cmd;
        sdram_ba   = init_ba;
        sdram_addr = init_addr;
        case (state_q)
            StArbit: begin
                sdram_cmd  = CmdNop;
                sdram_ba   = {BA_W{1'b1}};
                sdram_addr = {ADDR_W{1'b1}};
            end
            StAref: begin
                sdram_cmd  = aref_cmd;
                sdram_ba   = aref_ba;
                sdram_addr = aref_addr;
            end
            StWrite: begin
                sdram_cmd  = wr_cmd;
                sdram_ba   = wr_ba;
                sdram_addr = wr_addr;
            end
            StRead: begin
                sdram_cmd  = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: begin
                sdram_cmd  = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
        endcase
    end

    assign sdram_dq_oe  = wr_en & wr_dq_en;
    assign sdram_dq_out = sdram_dq_oe ? wr_data : {DATA_W{1'b0}};

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
//   Directed checks with literal expectations, followed by randomized traffic.
//   A bus-owner model tracks which master holds the pins. A compare process
//   checks every DUT output against that model on each falling edge.
module tb_sdram_arbiter;

    localparam int ADDR_W = 13;
    localparam int BA_W   = 2;
    localparam int DATA_W = 16;

    // Owner ids used by the model.
    localparam int OwnInit = 0, OwnArbit = 1, OwnAref = 2, OwnWrite = 3, OwnRead = 4;

    logic              clk, rst_n;
    logic [3:0]        init_cmd, aref_cmd, wr_cmd, rd_cmd;
    logic [BA_W-1:0]   init_ba, aref_ba, wr_ba, rd_ba;
    logic [ADDR_W-1:0] init_addr, aref_addr, wr_addr, rd_addr;
    logic              init_end, aref_req, aref_end, wr_req, wr_end, wr_dq_en;
    logic              rd_req, rd_end;
    logic [DATA_W-1:0] wr_data;
    logic              aref_en, wr_en, rd_en, sdram_cke, sdram_dq_oe;
    logic [3:0]        sdram_cmd;
    logic [BA_W-1:0]   sdram_ba;
    logic [ADDR_W-1:0] sdram_addr;
    logic [DATA_W-1:0] sdram_dq_out;

    int compared   = 0;
    int mismatched = 0;

    sdram_arbiter #(.ADDR_W(ADDR_W), .BA_W(BA_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr), .init_end(init_end),
        .aref_req(aref_req), .aref_cmd(aref_cmd), .aref_ba(aref_ba), .aref_addr(aref_addr),
        .aref_end(aref_end),
        .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr), .wr_end(wr_end),
        .wr_dq_en(wr_dq_en), .wr_data(wr_data),
        .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr), .rd_end(rd_end),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke),
        .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
        .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_owner;
    bit m_cke;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= OwnInit;
            m_cke   <= 1'b0;
        end else begin
            m_cke <= 1'b1;
            if (m_owner == OwnInit && init_end)                m_owner <= OwnArbit;
            else if (m_owner == OwnArbit) begin
                if (aref_req)     m_owner <= OwnAref;
                else if (wr_req)  m_owner <= OwnWrite;
                else if (rd_req)  m_owner <= OwnRead;
            end
            else if (m_owner == OwnAref  && aref_end)          m_owner <= OwnArbit;
            else if (m_owner == OwnWrite && wr_end)            m_owner <= OwnArbit;
            else if (m_owner == OwnRead  && rd_end)            m_owner <= OwnArbit;
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [3:0]        e_cmd;
            logic [BA_W-1:0]   e_ba;
            logic [ADDR_W-1:0] e_addr;
            bit                e_oe;
            e_cmd = init_cmd; e_ba = init_ba; e_addr = init_addr;
            if (m_owner == OwnArbit) begin
                e_cmd = 4'b0111; e_ba = '1; e_addr = '1;
            end else if (m_owner == OwnAref) begin
                e_cmd = aref_cmd; e_ba = aref_ba; e_addr = aref_addr;
            end else if (m_owner == OwnWrite) begin
                e_cmd = wr_cmd; e_ba = wr_ba; e_addr = wr_addr;
            end else if (m_owner == OwnRead) begin
                e_cmd = rd_cmd; e_ba = rd_ba; e_addr = rd_addr;
            end
            e_oe = (m_owner == OwnWrite) && wr_dq_en;
            check("model_aref_en", 32'(aref_en), 32'(m_owner == OwnAref));
            check("model_wr_en", 32'(wr_en), 32'(m_owner == OwnWrite));
            check("model_rd_en", 32'(rd_en), 32'(m_owner == OwnRead));
            check("model_cke", 32'(sdram_cke), 32'(m_cke));
            check("model_cmd", 32'(sdram_cmd), 32'(e_cmd));
            check("model_ba", 32'(sdram_ba), 32'(e_ba));
            check("model_addr", 32'(sdram_addr), 32'(e_addr));
            check("model_dq_oe", 32'(sdram_dq_oe), 32'(e_oe));
            check("model_dq_out", 32'(sdram_dq_out), e_oe ? 32'(wr_data) : 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Time-limit guard so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        init_cmd = 4'b0010; init_ba = 2'b01; init_addr = 13'h0400; init_end = 1'b0;
        aref_req = 0; aref_cmd = 4'b0001; aref_ba = 2'b00; aref_addr = 13'h0000; aref_end = 0;
        wr_req = 0; wr_cmd = 4'b0100; wr_ba = 2'b10; wr_addr = 13'h0123; wr_end = 0;
        wr_dq_en = 0; wr_data = 16'h0000;
        rd_req = 0; rd_cmd = 4'b0101; rd_ba = 2'b11; rd_addr = 13'h0456; rd_end = 0;
        cmp_en = 1'b1;
        #22;
        check("rst_cke", 32'(sdram_cke), 32'h0);
        check("rst_cmd", 32'(sdram_cmd), 32'h2);
        check("rst_dq_oe", 32'(sdram_dq_oe), 32'h0);
        rst_n = 1'b1;
        tick();
        check("cke_after_1", 32'(sdram_cke), 32'h1);
        repeat (49) tick();
        check("init_hold_cmd", 32'(sdram_cmd), 32'h2);
        check("init_hold_addr", 32'(sdram_addr), 32'h0400);
        check("init_hold_grants", {29'h0, aref_en, wr_en, rd_en}, 32'h0);

        init_end = 1'b1;
        tick();
        check("arbit_nop_cmd", 32'(sdram_cmd), 32'h7);
        check("arbit_ba", 32'(sdram_ba), 32'h3);
        check("arbit_addr", 32'(sdram_addr), 32'h1fff);
        aref_req = 1; wr_req = 1; rd_req = 1;
        tick();
        check("prio_grants", {29'h0, aref_en, wr_en, rd_en}, 32'h4);
        check("aref_cmd_pin", 32'(sdram_cmd), 32'h1);

        // Stray rd_end while refresh owns the bus.
        rd_end = 1; tick(); rd_end = 0;
        check("spurious_rd_end", 32'(aref_en), 32'h1);
        tick();
        check("aref_still", 32'(aref_en), 32'h1);
        aref_end = 1; tick(); aref_end = 0; aref_req = 0;
        check("aref_done_nop", 32'(sdram_cmd), 32'h7);
        tick();
        check("write_granted", {29'h0, aref_en, wr_en, rd_en}, 32'h2);
        wr_dq_en = 1; wr_data = 16'hA5A5; #1;
        check("wr_dq_oe", 32'(sdram_dq_oe), 32'h1);
        check("wr_dq_out", 32'(sdram_dq_out), 32'hA5A5);
        aref_req = 1;
        repeat (3) tick();
        check("no_preempt", {29'h0, aref_en, wr_en, rd_en}, 32'h2);
        wr_end = 1; tick(); wr_end = 0;
        check("gap_nop", 32'(sdram_cmd), 32'h7);
        check("gap_grants", {29'h0, aref_en, wr_en, rd_en}, 32'h0);
        check("gap_dq_oe", 32'(sdram_dq_oe), 32'h0);
        tick();
        check("aref_after_write", 32'(aref_en), 32'h1);
        aref_req = 0; wr_req = 0; aref_end = 1; tick(); aref_end = 0;
        tick();
        check("read_granted", {29'h0, aref_en, wr_en, rd_en}, 32'h1);
        check("read_dq_oe", 32'(sdram_dq_oe), 32'h0);
        check("read_dq_out", 32'(sdram_dq_out), 32'h0);

        // Asynchronous reset in the middle of a read burst.
        #2 rst_n = 1'b0; #1;
        check("midrst_rd_en", 32'(rd_en), 32'h0);
        check("midrst_cke", 32'(sdram_cke), 32'h0);
        check("midrst_cmd", 32'(sdram_cmd), 32'h2);
        check("midrst_dq_oe", 32'(sdram_dq_oe), 32'h0);
        tick();
        rst_n = 1'b1; init_end = 1'b0;
        tick();
        check("post_rst_init", {29'h0, aref_en, wr_en, rd_en}, 32'h0);
        check("post_rst_cmd", 32'(sdram_cmd), 32'h2);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            init_end = ($urandom_range(0, 3) != 0);
            aref_req = ($urandom_range(0, 3) == 0);
            wr_req   = $urandom_range(0, 1) == 1;
            rd_req   = $urandom_range(0, 1) == 1;
            aref_end = ($urandom_range(0, 5) == 0);
            wr_end   = ($urandom_range(0, 5) == 0);
            rd_end   = ($urandom_range(0, 5) == 0);
            wr_dq_en = $urandom_range(0, 1) == 1;
            wr_data  = 16'($urandom);
            init_cmd = 4'($urandom); aref_cmd = 4'($urandom);
            wr_cmd   = 4'($urandom); rd_cmd   = 4'($urandom);
            init_ba  = 2'($urandom); aref_ba  = 2'($urandom);
            wr_ba    = 2'($urandom); rd_ba    = 2'($urandom);
            init_addr = 13'($urandom); aref_addr = 13'($urandom);
            wr_addr   = 13'($urandom); rd_addr   = 13'($urandom);
            rst_n = ($urandom_range(0, 499) != 0);
            tick();
        end
        rst_n = 1'b1;
        tick();
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
